// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: widths, the "value valid" tag marker and entry states shared by
// the current-instruction stage, register bank and reservation stations.
package tomasulo_pkg;
    localparam int OP_W  = 6;
    localparam int TAG_W = 5;
    localparam int VAL_W = 32;
    localparam int ICC_W = 4;
    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;
    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} rs_state_t;
endpackage

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot; captures an issue, forwards/snoops CDB
// values into missing operands and walks FREE -> WAIT -> READY -> EXEC -> FREE.
module rs_entry import tomasulo_pkg::*; #(
    parameter logic [TAG_W-1:0] MY_TAG      = '0,
    parameter logic [TAG_W-1:0] INVALID_TAG = tomasulo_pkg::INVALID_TAG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [OP_W-1:0]  op_in,
    input  logic [VAL_W-1:0] val_1_in,
    input  logic [VAL_W-1:0] val_2_in,
    input  logic [TAG_W-1:0] tag_1_in,
    input  logic [TAG_W-1:0] tag_2_in,
    input  logic [ICC_W-1:0] icc_in,
    input  logic             dispatch,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [VAL_W-1:0] cdb_val,
    output logic             is_free,
    output logic             is_ready,
    output logic             free_next,
    output logic [OP_W-1:0]  op,
    output logic [VAL_W-1:0] val_1,
    output logic [VAL_W-1:0] val_2,
    output logic [ICC_W-1:0] icc
);
    rs_state_t state, state_nx;
    logic [TAG_W-1:0] tag_1, tag_2, t1_src, t2_src, t1_nx, t2_nx;
    logic [VAL_W-1:0] v1_nx, v2_nx;
    logic hit_1, hit_2, rdy, release_hit;

    // The same match logic serves issue-time forwarding and snooping of held tags.
    always_comb begin
        t1_src = alloc ? tag_1_in : tag_1;
        t2_src = alloc ? tag_2_in : tag_2;
        hit_1 = cdb_valid && t1_src != INVALID_TAG && t1_src == cdb_tag;
        hit_2 = cdb_valid && t2_src != INVALID_TAG && t2_src == cdb_tag;
        v1_nx = hit_1 ? cdb_val : (alloc ? val_1_in : val_1);
        v2_nx = hit_2 ? cdb_val : (alloc ? val_2_in : val_2);
        t1_nx = hit_1 ? INVALID_TAG : t1_src;
        t2_nx = hit_2 ? INVALID_TAG : t2_src;
        rdy = t1_nx == INVALID_TAG && t2_nx == INVALID_TAG;
        release_hit = state == EXEC && cdb_valid && cdb_tag == MY_TAG;
        state_nx = alloc ? (rdy ? READY : WAIT) :
                   (state == WAIT && rdy) ? READY :
                   dispatch ? EXEC :
                   release_hit ? FREE : state;
    end

    assign is_free   = state == FREE;
    assign is_ready  = state == READY;
    assign free_next = state_nx == FREE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
            tag_1 <= INVALID_TAG;
            tag_2 <= INVALID_TAG;
            val_1 <= '0;
            val_2 <= '0;
            op    <= '0;
            icc   <= '0;
        end else begin
            state <= state_nx;
            tag_1 <= t1_nx;
            tag_2 <= t2_nx;
            val_1 <= v1_nx;
            val_2 <= v2_nx;
            op    <= alloc ? op_in : op;
            icc   <= alloc ? icc_in : icc;
        end
    end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: entry array with lowest-index allocate/dispatch priority
// encoders and registered issue-ack and functional-unit outputs.
module reservation_station import tomasulo_pkg::*; #(
    parameter int               ENTRIES     = 4,
    parameter logic [TAG_W-1:0] TAG_BASE    = 5'd0,
    parameter logic [TAG_W-1:0] INVALID_TAG = tomasulo_pkg::INVALID_TAG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_issue_enable,
    input  logic [OP_W-1:0]  in_operator_type,
    input  logic [VAL_W-1:0] in_val_1,
    input  logic [VAL_W-1:0] in_val_2,
    input  logic [TAG_W-1:0] in_tag_1,
    input  logic [TAG_W-1:0] in_tag_2,
    input  logic [ICC_W-1:0] in_ICC_flags,
    output logic             out_issue_ack,
    output logic [TAG_W-1:0] out_issue_tag,
    output logic             out_full,
    input  logic             in_CDB_broadcast,
    input  logic [TAG_W-1:0] in_CDB_tag,
    input  logic [VAL_W-1:0] in_CDB_val,
    input  logic             in_fu_ready,
    output logic             out_fu_enable,
    output logic [OP_W-1:0]  out_fu_operator_type,
    output logic [VAL_W-1:0] out_fu_val_1,
    output logic [VAL_W-1:0] out_fu_val_2,
    output logic [ICC_W-1:0] out_fu_ICC_flags,
    output logic [TAG_W-1:0] out_fu_tag
);
    logic [ENTRIES-1:0] is_free, is_ready, free_next, alloc, dispatch;
    logic [OP_W-1:0]  op    [ENTRIES];
    logic [VAL_W-1:0] val_1 [ENTRIES];
    logic [VAL_W-1:0] val_2 [ENTRIES];
    logic [ICC_W-1:0] icc   [ENTRIES];
    logic [TAG_W-1:0] alloc_tag, sel_tag;
    logic [OP_W-1:0]  sel_op;
    logic [VAL_W-1:0] sel_v1, sel_v2;
    logic [ICC_W-1:0] sel_icc;

    // x & -x isolates the lowest set bit; a request seen in its ack cycle is ignored.
    assign alloc    = is_free & -is_free & {ENTRIES{in_issue_enable && !out_issue_ack}};
    assign dispatch = is_ready & -is_ready & {ENTRIES{in_fu_ready}};

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        rs_entry #(.MY_TAG(TAG_BASE + TAG_W'(e)), .INVALID_TAG(INVALID_TAG)) u_entry (
            .clk(clk), .rst(rst), .alloc(alloc[e]),
            .op_in(in_operator_type), .val_1_in(in_val_1), .val_2_in(in_val_2),
            .tag_1_in(in_tag_1), .tag_2_in(in_tag_2), .icc_in(in_ICC_flags),
            .dispatch(dispatch[e]), .cdb_valid(in_CDB_broadcast),
            .cdb_tag(in_CDB_tag), .cdb_val(in_CDB_val),
            .is_free(is_free[e]), .is_ready(is_ready[e]), .free_next(free_next[e]),
            .op(op[e]), .val_1(val_1[e]), .val_2(val_2[e]), .icc(icc[e])
        );
    end

    always_comb begin
        alloc_tag = INVALID_TAG;
        sel_tag = INVALID_TAG;
        sel_op = '0;
        sel_v1 = '0;
        sel_v2 = '0;
        sel_icc = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            alloc_tag = alloc[i] ? TAG_BASE + TAG_W'(i) : alloc_tag;
            if (dispatch[i]) begin
                sel_tag = TAG_BASE + TAG_W'(i);
                sel_op = op[i];
                sel_v1 = val_1[i];
                sel_v2 = val_2[i];
                sel_icc = icc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_issue_ack        <= 1'b0;
            out_issue_tag        <= INVALID_TAG;
            out_full             <= 1'b0;
            out_fu_enable        <= 1'b0;
            out_fu_operator_type <= '0;
            out_fu_val_1         <= '0;
            out_fu_val_2         <= '0;
            out_fu_ICC_flags     <= '0;
            out_fu_tag           <= INVALID_TAG;
        end else begin
            out_issue_ack <= |alloc;
            out_issue_tag <= alloc_tag;
            out_full      <= ~|free_next;
            out_fu_enable <= |dispatch;
            if (|dispatch) begin
                out_fu_operator_type <= sel_op;
                out_fu_val_1         <= sel_v1;
                out_fu_val_2         <= sel_v2;
                out_fu_ICC_flags     <= sel_icc;
                out_fu_tag           <= sel_tag;
            end
        end
    end
endmodule
